register_serializer: RTL and testbench

REGISTER_SERIALIZER -- requirements
Module: register_serializer

---
 rtl/register_serializer.sv | 131 +++++++++++++
 tb/tb_register_serializer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/register_serializer.sv
// Parallel-to-serial shifter with a valid/enable handshake and a one-cycle Done pulse.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module register_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] DataInput,
  input  logic             Enable,
  output logic             DataOutput,
  output logic             Valid,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             dout_d, valid_d, busy_d, done_d;
  logic             xfer;
`ifdef SERIALIZER_PARITY_EN
  logic             parity, parity_d;
`endif

  assign xfer = Valid & Enable;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state;
    sreg_d   = sreg;
    cnt_d    = cnt;
    dout_d   = DataOutput;
    valid_d  = Valid;
    busy_d   = Busy;
    done_d   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d = parity;
`endif
    unique case (state)
      IDLE: begin
        if (Load) begin
          sreg_d  = DataInput;
          cnt_d   = CW'(WIDTH);
          dout_d  = MSB_FIRST ? DataInput[WIDTH-1] : DataInput[0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef SERIALIZER_PARITY_EN
          parity_d = ^DataInput;
`endif
        end
      end
      SHIFT: begin
        if (xfer && cnt != '0) begin
          cnt_d = cnt - CW'(1);
          if (cnt == CW'(1)) begin
`ifdef SERIALIZER_PARITY_EN
            state_d = PARITY;
            dout_d  = parity;
`else
            state_d = IDLE;
            dout_d  = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else if (MSB_FIRST) begin
            sreg_d = {sreg[WIDTH-2:0], 1'b0};
            dout_d = sreg[WIDTH-2];
          end else begin
            sreg_d = {1'b0, sreg[WIDTH-1:1]};
            dout_d = sreg[1];
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        if (xfer) begin
          state_d = IDLE;
          dout_d  = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values. The shift register is reset too, so an aborted
  // word leaves no residue that could be observed later.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      DataOutput <= 1'b0;
      Valid      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      sreg       <= sreg_d;
      cnt        <= cnt_d;
      DataOutput <= dout_d;
      Valid      <= valid_d;
      Busy       <= busy_d;
      Done       <= done_d;
`ifdef SERIALIZER_PARITY_EN
      parity     <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_register_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus; a word-level
// model pushes expected bits on accepted Loads, a negedge monitor pops them on transfers.
module tb_register_serializer;
  localparam int WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [1:0]       dout, valid, busy, done;

  always #5 clk = ~clk;

  register_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .CLK(clk), .Reset(rst_n), .Load(load), .DataInput(din), .Enable(en),
    .DataOutput(dout[0]), .Valid(valid[0]), .Busy(busy[0]), .Done(done[0])
  );

  register_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(clk), .Reset(rst_n), .Load(load), .DataInput(din), .Enable(en),
    .DataOutput(dout[1]), .Valid(valid[1]), .Busy(busy[1]), .Done(done[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level reference: a word occupies NBITS transfers; Load is taken only when none remain.
  bit q_msb[$];
  bit q_lsb[$];
  int remaining = 0;
  bit done_exp  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_msb.delete();
      q_lsb.delete();
      remaining = 0;
      done_exp  = 1'b0;
    end else begin
      done_exp = 1'b0;
      if (remaining > 0) begin
        if (en) begin
          remaining--;
          if (remaining == 0) done_exp = 1'b1;
        end
      end else if (load) begin
        for (int j = 0; j < WIDTH; j++) begin
          q_msb.push_back(din[WIDTH-1-j]);
          q_lsb.push_back(din[j]);
        end
`ifdef SERIALIZER_PARITY_EN
        q_msb.push_back(^din);
        q_lsb.push_back(^din);
`endif
        remaining = NBITS;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_bit;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("valid[%0d]", i), {31'd0, valid[i]}, {31'd0, remaining > 0});
      check($sformatf("busy[%0d]", i), {31'd0, busy[i]}, {31'd0, remaining > 0});
      check($sformatf("done[%0d]", i), {31'd0, done[i]}, {31'd0, done_exp});
      if (!valid[i]) begin
        check($sformatf("idle_dout[%0d]", i), {31'd0, dout[i]}, 32'd0);
      end else if (en) begin
        check($sformatf("queue_has_bit[%0d]", i), (i == 0 ? q_msb.size() : q_lsb.size()) > 0, 32'd1);
        if (i == 0 && q_msb.size() > 0) begin
          exp_bit = q_msb.pop_front();
          check("bit[msb]", {31'd0, dout[0]}, {31'd0, exp_bit});
        end else if (i == 1 && q_lsb.size() > 0) begin
          exp_bit = q_lsb.pop_front();
          check("bit[lsb]", {31'd0, dout[1]}, {31'd0, exp_bit});
        end
      end
    end
  end

  task automatic cyc(input bit l, input logic [WIDTH-1:0] d, input bit e);
    load = l;
    din  = d;
    en   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(1'b0, WIDTH'($urandom), 1'b1);
  endtask

  initial begin
    #1;
    check("reset_outputs", {28'd0, dout[0], valid[0], busy[0], done[0]}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // A5, Enable held high, Load on the first edge after reset release.
    cyc(1'b1, 8'hA5, 1'b1);
    repeat (NBITS + 2) cyc(1'b0, WIDTH'($urandom), 1'b1);

    // 01 with Enable toggling: bits must hold across stalls.
    cyc(1'b1, 8'h01, 1'b0);
    for (int k = 0; k < 2 * NBITS + 4; k++) cyc(1'b0, WIDTH'($urandom), (k % 2) == 0);

    // FF then a Load of 00 on the third cycle of the word must be ignored.
    cyc(1'b1, 8'hFF, 1'b1);
    cyc(1'b0, 8'hFF, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);
    drain(NBITS + 3);

    // C3 aborted by asynchronous reset after the fourth transfer.
    cyc(1'b1, 8'hC3, 1'b1);
    repeat (4) cyc(1'b0, 8'hC3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_msb", {29'd0, valid[0], busy[0], dout[0]}, 32'd0);
    check("async_reset_lsb", {29'd0, valid[1], busy[1], dout[1]}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 8'h81, 1'b1);
    drain(NBITS + 3);

    // Load during the Done cycle is accepted.
    cyc(1'b1, 8'h5A, 1'b1);
    repeat (NBITS) cyc(1'b0, WIDTH'($urandom), 1'b1);
    check("done_cycle_seen", {31'd0, done[0]}, 32'd1);
    cyc(1'b1, 8'h3C, 1'b1);
    check("done_load_valid", {31'd0, valid[0]}, 32'd1);
    check("done_load_first_bit_msb", {31'd0, dout[0]}, 32'd0);
    check("done_load_first_bit_lsb", {31'd0, dout[1]}, 32'd0);
    drain(NBITS + 3);

    // Random traffic with stalls and Loads arriving at arbitrary points.
    repeat (600) cyc(($urandom % 4) == 0, WIDTH'($urandom), ($urandom % 4) != 0);
    drain(3 * NBITS);
    check("queue_empty_msb", q_msb.size(), 32'd0);
    check("queue_empty_lsb", q_lsb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
